fft_stream_seq: RTL
===================

Name: fft_stream_seq

Overview:
- Frame sequencer in front of the streaming FFT stage chain (stage1 onward); the chain runs on a free counter restarted by `clear` and has no enables.
- Accepts a valid/sof sample stream and feeds the chain continuous, frame-aligned samples.
- Drives the chain's clear so that sample index 0 lands on chain count 0, zero-fills underruns, and drains the pipeline with zeros after the last frame.
- Tags chain output with valid/sof aligned to the chain latency.

Parameters:
- DBW, 3, bits per real/imag component; samples are 2*DBW wide.
- CBW, 3, log2 of frame length N (N = 1<<CBW); must match the stage chain.
- LAT, 9, cycles from a sample on st_din to its result on st_dout; must be >= 1.

Ports:
- clk  input  1  clock
- clear  input  1  synchronous active-high reset
- in_valid  input  1  input sample valid
- in_sof  input  1  marks sample index 0 of a frame
- in_data  input  2*DBW  input sample {im,re}
- in_ready  output  1  block accepts in_data this cycle
- st_clear  output  1  registered clear to stage chain
- st_din  output  2*DBW  registered sample to stage chain
- st_dout  input  2*DBW  stage chain output
- out_valid  output  1  out_data holds a frame result
- out_sof  output  1  out_data is result index 0
- out_data  output  2*DBW  registered copy of st_dout
- underrun  output  1  one-cycle pulse: zero inserted mid-frame
- sof_err  output  1  one-cycle pulse: non-sof sample at frame boundary, dropped
- busy  output  1  state is RUN or FLUSH

Behaviour:
- Reset (clear=1): state IDLE, cnt=0, flush counter=0, tag pipeline=0.
  - Next cycle: st_clear=1, st_din=0, out_valid=0, out_sof=0, out_data=0, underrun=0, sof_err=0, busy=0.
  - in_ready=0 while clear is high.
- in_ready is combinational from state: 1 in IDLE and RUN, 0 in FLUSH.
- IDLE:
  - st_clear=1, st_din=0.
  - in_valid=1 with in_sof=1 in cycle t: sample accepted; at t+1 st_din=in_data, st_clear=0, cnt=1, go RUN.
  - in_valid=1 with in_sof=0: sample dropped silently, no sof_err.
- RUN (cnt = index of the next sample within the frame):
  - cnt!=0:
    - in_valid=1: forward in_data, cnt+1. in_sof is ignored.
    - in_valid=0: st_din=0, underrun pulses, cnt+1. The frame length is preserved.
  - cnt==0 (frame boundary):
    - in_valid=1 and in_sof=1: forward, continue RUN back-to-back, no gap.
    - in_valid=1 and in_sof=0: sample dropped, sof_err pulses, go FLUSH.
    - in_valid=0: go FLUSH.
  - cnt wraps modulo N.
- FLUSH:
  - st_din=0 for exactly LAT cycles, then go IDLE; st_clear=1 from the following cycle.
  - New input is not accepted until IDLE.
- Tagging:
  - Each st_din cycle carries tag {v,s}.
    - v=1 for every frame slot, including underrun zeros; v=0 for flush zeros.
    - s=1 for index 0.
  - Tags are delayed LAT+1 cycles. out_data <= st_dout.
  - out_valid/out_sof therefore align with out_data.
  - Latency: accept at t gives the corresponding out_data at t+LAT+2.
- Simultaneous events: clear overrides everything. A mid-frame clear aborts the frame and kills its in-flight tags; the partial output is never marked valid.

Optional Feature:
- FFT_SEQ_STATS_EN defined:
  - Adds outputs frame_cnt[15:0] (frames started, wraps at 65535->0) and err_cnt[15:0] (underrun + sof_err events, saturates at 65535).
  - Both are zeroed by clear.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan (N=8, LAT=9, DBW=3):
- Single frame: clear, then samples 1..8 contiguous with sof on 1, first accepted at cycle t.
  - st_clear falls at t+1.
  - out_valid is high exactly cycles t+11..t+18; out_sof only at t+11.
  - FLUSH lasts 9 cycles; busy=0 and st_clear=1 afterwards.
- Back-to-back: 16 contiguous samples with sof at indices 0 and 8.
  - No FLUSH between frames; out_valid high 16 contiguous cycles.
  - out_sof on output cycles 0 and 8.
- Underrun: in_valid low for one cycle at index 3.
  - st_din=0 in that slot; underrun pulses once.
  - Exactly 8 valid outputs; the next frame's sof is still accepted at index 0.
- sof error: after a full frame, in_valid=1 with in_sof=0.
  - Sample dropped; sof_err pulses once; state goes FLUSH; in_ready=0 for 9 cycles.
- Mid-frame clear: assert clear at index 5.
  - Next cycle: busy=0, st_clear=1, out_valid=0; no valid outputs from the aborted frame ever appear.
  - A following sof frame produces 8 correct tagged outputs.
- Stats (macro defined): 3 frames with 2 underruns.
  - frame_cnt=3, err_cnt=2; both are 0 after clear.

Source files
------------

// File: rtl/fft_stream_seq.sv
// Frame sequencer in front of the streaming FFT stage chain: aligns frames to the chain counter,
// zero-fills underruns, drains with zeros and tags results. Optional counters: FFT_SEQ_STATS_EN.
module fft_stream_seq #(
  parameter int DBW = 3,
  parameter int CBW = 3,
  parameter int LAT = 9
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [2*DBW-1:0] in_data,
  output logic             in_ready,
  output logic             st_clear,
  output logic [2*DBW-1:0] st_din,
  input  logic [2*DBW-1:0] st_dout,
  output logic             out_valid,
  output logic             out_sof,
  output logic [2*DBW-1:0] out_data,
  output logic             underrun,
  output logic             sof_err,
  output logic             busy
`ifdef FFT_SEQ_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam int SW = 2*DBW;
  localparam int FW = $clog2(LAT+1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CBW-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              st_clear_q, st_clear_d;
  logic [SW-1:0]     st_din_q, st_din_d;
  logic [SW-1:0]     out_data_q;
  logic              underrun_q, underrun_d;
  logic              sof_err_q, sof_err_d;
  // {valid, sof} per st_din slot; index 0 travels with st_din, LAT+1 with out_data
  logic [LAT+1:0][1:0] tag_pipe_q;
  logic [1:0]        tag_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    st_clear_d = 1'b0;
    st_din_d   = '0;
    tag_d      = 2'b00;
    underrun_d = 1'b0;
    sof_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        st_clear_d = 1'b1;
        if (in_valid && in_sof) begin
          st_clear_d = 1'b0;
          st_din_d   = in_data;
          tag_d      = 2'b11;
          cnt_d      = CBW'(1);
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          tag_d = 2'b10;
          cnt_d = cnt_q + CBW'(1);
          if (in_valid) st_din_d = in_data;
          else          underrun_d = 1'b1;
        end else if (in_valid && in_sof) begin
          st_din_d = in_data;
          tag_d    = 2'b11;
          cnt_d    = CBW'(1);
        end else begin
          // frame boundary without a new sof: drain the chain
          state_d   = FLUSH;
          fcnt_d    = '0;
          sof_err_d = in_valid;
        end
      end
      FLUSH: begin
        if (fcnt_q == FW'(LAT-1)) begin
          state_d    = IDLE;
          st_clear_d = 1'b1;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      st_clear_q <= 1'b1;
      st_din_q   <= '0;
      out_data_q <= '0;
      underrun_q <= 1'b0;
      sof_err_q  <= 1'b0;
      tag_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      st_clear_q <= st_clear_d;
      st_din_q   <= st_din_d;
      out_data_q <= st_dout;
      underrun_q <= underrun_d;
      sof_err_q  <= sof_err_d;
      tag_pipe_q <= {tag_pipe_q[LAT:0], tag_d};
    end
  end

  assign in_ready  = !clear && (state_q == IDLE || state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == FLUSH);
  assign st_clear  = st_clear_q;
  assign st_din    = st_din_q;
  assign out_data  = out_data_q;
  assign out_valid = tag_pipe_q[LAT+1][1];
  assign out_sof   = tag_pipe_q[LAT+1][0];
  assign underrun  = underrun_q;
  assign sof_err   = sof_err_q;

`ifdef FFT_SEQ_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;
  logic        frame_start;
  logic        err_evt;

  assign frame_start = in_valid && in_sof &&
                       (state_q == IDLE || (state_q == RUN && cnt_q == '0));
  assign err_evt     = underrun_d || sof_err_d;

  always_ff @(posedge clk) begin
    if (clear) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_evt && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
